// File: rtl/saph_vga_pkg.sv
// Types shared between the per-axis VGA timing generator and its measurer.
// Phase order matches the generator: FP -> VID -> BP -> SYNC -> FP.
package saph_vga_pkg;

  typedef enum logic [1:0] {
    FP   = 2'd0,
    VID  = 2'd1,
    BP   = 2'd2,
    SYNC = 2'd3
  } saph_vga_phase_t;

  // Successor of a phase in generator order (SYNC wraps back to FP).
  function automatic saph_vga_phase_t saph_vga_next_phase(input saph_vga_phase_t p);
    return saph_vga_phase_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/saph_vga_timing_meas.sv
// Single-axis VGA timing measurer: recovers FP/VID/BP/SYNC run lengths
// (published as length-1) from vid_en/sync_en and tracks lock on a stable timing.
module saph_vga_timing_meas
  import saph_vga_pkg::*;
#(
  parameter int width      = 9,
  parameter int lock_count = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             vid_en,
  input  logic             sync_en,
  output logic [width-1:0] fp_width,
  output logic [width-1:0] vid_width,
  output logic [width-1:0] bp_width,
  output logic [width-1:0] sync_width,
  output logic             valid,
  output logic             locked,
  output logic             err,
  output logic             wrap
);

  localparam int MW = (lock_count < 1) ? 1 : $clog2(lock_count + 1);
  localparam logic [MW-1:0]    LOCK_N  = MW'(lock_count);
  localparam logic [width-1:0] CNT_MAX = '1;

  logic             hunt_q, hunt_d;
  logic             sync_seen_q, sync_seen_d;
  saph_vga_phase_t  phase_q, phase_d;
  logic [width-1:0] cnt_q, cnt_d;
  saph_vga_phase_t  cls;
  logic             ev_err, ev_adv, ev_wrap;

  // A gap sample extends FP after SYNC/FP and BP after VID/BP.
  always_comb begin
    if (sync_en)                              cls = SYNC;
    else if (vid_en)                          cls = VID;
    else if (phase_q == SYNC || phase_q == FP) cls = FP;
    else                                      cls = BP;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hunt_q      <= 1'b1;
      sync_seen_q <= 1'b0;
      phase_q     <= FP;
      cnt_q       <= '0;
    end else begin
      hunt_q      <= hunt_d;
      sync_seen_q <= sync_seen_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next state: only the successor phase is a legal change.
  always_comb begin
    hunt_d      = hunt_q;
    sync_seen_d = sync_seen_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    ev_err      = 1'b0;
    ev_adv      = 1'b0;
    ev_wrap     = 1'b0;
    if (inc) begin
      if (hunt_q) begin
        if (sync_en) begin
          sync_seen_d = 1'b1;
        end else if (sync_seen_q) begin
          hunt_d      = 1'b0;
          sync_seen_d = 1'b0;
          phase_d     = FP;
          cnt_d       = '0;
        end
      end else if (vid_en && sync_en) begin
        ev_err = 1'b1;
      end else if (cls == phase_q) begin
        if (cnt_q == CNT_MAX) ev_err = 1'b1;
        else                  cnt_d  = cnt_q + 1'b1;
      end else if (cls == saph_vga_next_phase(phase_q)) begin
        ev_adv  = 1'b1;
        ev_wrap = (phase_q == SYNC);
        phase_d = cls;
        cnt_d   = '0;
      end else begin
        ev_err = 1'b1;
      end
      if (ev_err) begin
        hunt_d      = 1'b1;
        sync_seen_d = 1'b0;
        cnt_d       = '0;
      end
    end
  end

  // Pulse outputs; reset masks any coincident event.
  always_comb begin
    err  = ev_err  & ~rst;
    wrap = ev_wrap & ~rst;
  end

  // Shadow bank for FP/VID/BP; the SYNC length is taken live from cnt_q.
  for (genvar gi = 0; gi < 3; gi++) begin : g_shadow
    logic [width-1:0] sh_q;
    always_ff @(posedge clk) begin
      if (rst)                                  sh_q <= '0;
      else if (ev_adv && (phase_q == 2'(gi)))   sh_q <= cnt_q;
    end
  end

  logic [width-1:0] fp_q, fp_d, vid_q, vid_d, bp_q, bp_d, sy_q, sy_d;
  logic             valid_q, valid_d, locked_q, locked_d;
  logic [MW-1:0]    match_q, match_d;
  logic             cand_diff;

  assign cand_diff = (g_shadow[0].sh_q != fp_q) || (g_shadow[1].sh_q != vid_q) ||
                     (g_shadow[2].sh_q != bp_q) || (cnt_q != sy_q);

  always_comb begin
    fp_d     = fp_q;
    vid_d    = vid_q;
    bp_d     = bp_q;
    sy_d     = sy_q;
    valid_d  = valid_q;
    locked_d = locked_q;
    match_d  = match_q;
    if (ev_err) begin
      match_d  = '0;
      locked_d = 1'b0;
    end else if (ev_wrap) begin
      if (!valid_q || cand_diff) begin
        fp_d     = g_shadow[0].sh_q;
        vid_d    = g_shadow[1].sh_q;
        bp_d     = g_shadow[2].sh_q;
        sy_d     = cnt_q;
        valid_d  = 1'b1;
        match_d  = '0;
        locked_d = 1'b0;
      end else begin
        if (match_q != LOCK_N) match_d = match_q + 1'b1;
        locked_d = (match_d == LOCK_N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fp_q     <= '0;
      vid_q    <= '0;
      bp_q     <= '0;
      sy_q     <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      match_q  <= '0;
    end else begin
      fp_q     <= fp_d;
      vid_q    <= vid_d;
      bp_q     <= bp_d;
      sy_q     <= sy_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      match_q  <= match_d;
    end
  end

  assign fp_width   = fp_q;
  assign vid_width  = vid_q;
  assign bp_width   = bp_q;
  assign sync_width = sy_q;
  assign valid      = valid_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_saph_vga_timing_meas.sv
// Directed bench: table of generator periods with expected published state,
// plus hand sequences for error, overflow and reset corner cases.
module tb_saph_vga_timing_meas;

  logic       clk = 1'b0;
  logic       rst = 1'b1, inc = 1'b0, vid_en = 1'b0, sync_en = 1'b0;
  logic [8:0] fp_width, vid_width, bp_width, sync_width;
  logic       valid, locked, err, wrap;
  logic [3:0] fp4, vid4, bp4, sync4;
  logic       valid4, locked4, err4, wrap4;

  int checks = 0, failures = 0;
  int wrap_seen = 0, err_seen = 0, idle_bad = 0;
  bit gap_mode = 1'b0;

  always #5 clk = ~clk;

  saph_vga_timing_meas #(.width(9), .lock_count(3)) dut (
    .clk(clk), .rst(rst), .inc(inc), .vid_en(vid_en), .sync_en(sync_en),
    .fp_width(fp_width), .vid_width(vid_width), .bp_width(bp_width),
    .sync_width(sync_width), .valid(valid), .locked(locked), .err(err), .wrap(wrap)
  );

  saph_vga_timing_meas #(.width(4), .lock_count(3)) dut4 (
    .clk(clk), .rst(rst), .inc(inc), .vid_en(vid_en), .sync_en(sync_en),
    .fp_width(fp4), .vid_width(vid4), .bp_width(bp4),
    .sync_width(sync4), .valid(valid4), .locked(locked4), .err(err4), .wrap(wrap4)
  );

  typedef struct {
    int fp, vid, bp, sy;
    int e_valid, e_locked, e_fp, e_vid, e_bp, e_sy, e_wraps;
  } row_t;
  row_t rows[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock: drive after the edge, observe pulses at the falling edge.
  task automatic drive(input logic i, input logic v, input logic s, input logic r);
    @(posedge clk);
    #1;
    inc = i; vid_en = v; sync_en = s; rst = r;
    @(negedge clk);
    if (i) begin
      wrap_seen += int'(wrap);
      err_seen  += int'(err);
    end else if (err || wrap) begin
      idle_bad++;
    end
  endtask

  // One inc sample; in gap mode it is followed by an inc=0 cycle with junk inputs.
  task automatic smp(input logic v, input logic s);
    drive(1'b1, v, s, 1'b0);
    if (gap_mode) drive(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic run(input int n, input logic v, input logic s);
    repeat (n) smp(v, s);
  endtask

  task automatic period(input int fp, input int vid, input int bp, input int sy);
    run(fp + 1, 1'b0, 1'b0);
    run(vid + 1, 1'b1, 1'b0);
    run(bp + 1, 1'b0, 1'b0);
    run(sy + 1, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_rows(input string tag, input int first, input int last);
    for (int r = first; r <= last; r++) begin
      wrap_seen = 0;
      err_seen  = 0;
      period(rows[r].fp, rows[r].vid, rows[r].bp, rows[r].sy);
      chk($sformatf("%s_row%0d_valid", tag, r),  int'(valid),      rows[r].e_valid);
      chk($sformatf("%s_row%0d_locked", tag, r), int'(locked),     rows[r].e_locked);
      chk($sformatf("%s_row%0d_fp", tag, r),     int'(fp_width),   rows[r].e_fp);
      chk($sformatf("%s_row%0d_vid", tag, r),    int'(vid_width),  rows[r].e_vid);
      chk($sformatf("%s_row%0d_bp", tag, r),     int'(bp_width),   rows[r].e_bp);
      chk($sformatf("%s_row%0d_sync", tag, r),   int'(sync_width), rows[r].e_sy);
      chk($sformatf("%s_row%0d_wraps", tag, r),  wrap_seen,        rows[r].e_wraps);
      chk($sformatf("%s_row%0d_errs", tag, r),   err_seen,         0);
      $display("%s row %0d: valid=%0d locked=%0d widths=%0d/%0d/%0d/%0d wraps=%0d",
               tag, r, valid, locked, fp_width, vid_width, bp_width, sync_width, wrap_seen);
    end
  endtask

  initial begin
    rows[0] = '{3, 15, 2, 4, 0, 0, 0,  0, 0, 0, 0};
    rows[1] = '{3, 15, 2, 4, 1, 0, 3, 15, 2, 4, 1};
    rows[2] = '{3, 15, 2, 4, 1, 0, 3, 15, 2, 4, 1};
    rows[3] = '{3, 15, 2, 4, 1, 0, 3, 15, 2, 4, 1};
    rows[4] = '{3, 15, 2, 4, 1, 1, 3, 15, 2, 4, 1};
    rows[5] = '{3, 19, 2, 4, 1, 1, 3, 15, 2, 4, 1};
    rows[6] = '{3, 19, 2, 4, 1, 0, 3, 19, 2, 4, 1};
    rows[7] = '{3, 19, 2, 4, 1, 0, 3, 19, 2, 4, 1};
    rows[8] = '{3, 19, 2, 4, 1, 0, 3, 19, 2, 4, 1};
    rows[9] = '{3, 19, 2, 4, 1, 1, 3, 19, 2, 4, 1};

    // Reset state
    do_reset();
    chk("reset_valid",  int'(valid),      0);
    chk("reset_locked", int'(locked),     0);
    chk("reset_fp",     int'(fp_width),   0);
    chk("reset_sync",   int'(sync_width), 0);
    chk("reset_err",    int'(err),        0);
    chk("reset_wrap",   int'(wrap),       0);

    // Measure, lock, then change vid length at a period boundary
    run(5, 1'b0, 1'b1);
    run_rows("t1", 0, 9);

    // inc every other clock, junk inputs while inc=0
    do_reset();
    gap_mode = 1'b1;
    idle_bad = 0;
    run(5, 1'b0, 1'b1);
    run_rows("t2", 0, 4);
    chk("t2_idle_quiet", idle_bad, 0);
    gap_mode = 1'b0;

    // vid_en and sync_en together mid-video
    wrap_seen = 0;
    err_seen  = 0;
    run(4, 1'b0, 1'b0);
    run(5, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4_err_pulse", int'(err), 1);
    smp(1'b1, 1'b0);
    chk("t4_locked_cleared", int'(locked),    0);
    chk("t4_valid_held",     int'(valid),     1);
    chk("t4_vid_held",       int'(vid_width), 15);
    chk("t4_fp_held",        int'(fp_width),  3);
    run(10, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0);
    run(5, 1'b0, 1'b1);
    for (int p = 1; p <= 4; p++) begin
      period(3, 15, 2, 4);
      if (p == 3) chk("t4_not_yet_locked", int'(locked), 0);
    end
    chk("t4_relocked", int'(locked), 1);
    chk("t4_wraps",    wrap_seen,    4);
    chk("t4_errs",     err_seen,     1);
    $display("t4: relocked=%0d wraps=%0d errs=%0d", locked, wrap_seen, err_seen);

    // Zero-length back porch
    run(4, 1'b0, 1'b0);
    run(16, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_zero_bp_err",  int'(err),  1);
    chk("t5_zero_bp_err4", int'(err4), 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_locked_cleared", int'(locked), 0);
    chk("t5_sync_held",      int'(sync_width), 4);
    run(3, 1'b0, 1'b1);

    // Sync overflow on the 4-bit instance at the 17th sample
    run(4, 1'b0, 1'b0);
    run(16, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0);
    run(15, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_no_ovf_at_16", int'(err4), 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_ovf_at_17",    int'(err4), 1);
    chk("t5_wide_no_ovf",  int'(err),  0);
    $display("t5: overflow sample err4=%0d err=%0d", err4, err);

    // Reset mid-video while locked, coincident with an error condition
    do_reset();
    run(5, 1'b0, 1'b1);
    run_rows("t6", 0, 4);
    run(4, 1'b0, 1'b0);
    run(5, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t6_err_suppressed", int'(err), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_valid_zero",  int'(valid),     0);
    chk("t6_locked_zero", int'(locked),    0);
    chk("t6_vid_zero",    int'(vid_width), 0);
    chk("t6_fp_zero",     int'(fp_width),  0);
    run(10, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0);
    run(5, 1'b0, 1'b1);
    wrap_seen = 0;
    period(3, 15, 2, 4);
    chk("t6_hunt_no_wrap", wrap_seen, 0);
    // Reset on the sample that would complete a period
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t6_wrap_suppressed", int'(wrap), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_valid_after_rst", int'(valid), 0);
    $display("t6: after reset valid=%0d locked=%0d", valid, locked);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
